spi_master_shifter: RTL and testbench

//  SPI mode-0 master shift engine. It sits between the SPI TX FIFO read port and the RX FIFO write port.
//  It pops one word from the TX FIFO and frames it with cs_n_o. It shifts the word out MSB-first on mosi_o.
//  It captures miso_i into a word and pushes that word into the RX FIFO.

---
 rtl/spi_master_shifter_if.sv | 22 ++
 rtl/spi_master_shifter.sv | 141 ++++++++++++++
 tb/tb_spi_master_shifter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_shifter_if.sv
// FIFO-side bundle of the SPI master shifter: TX FIFO read port and RX FIFO
// write port. master = shifter side, slave = FIFO side.
interface spi_master_shifter_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  tx_empty_i;
  logic                  tx_rd_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_full_i;
  logic                  rx_wr_o;

  modport master (
    input  tx_data_i, tx_empty_i, rx_full_i,
    output tx_rd_o, rx_data_o, rx_wr_o
  );

  modport slave (
    output tx_data_i, tx_empty_i, rx_full_i,
    input  tx_rd_o, rx_data_o, rx_wr_o
  );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI mode-0 master shift engine between TX FIFO read and RX FIFO write.
// Ports: clk_i, rst_i (sync, high), en_i, fifo (FIFO bundle, master),
//   sclk_o, mosi_o, miso_i, cs_n_o, busy_o, rx_ovf_o (sticky), ovf_clr_i.
module spi_master_shifter #(
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  spi_master_shifter_if.master fifo,
  output logic                sclk_o,
  output logic                mosi_o,
  input  logic                miso_i,
  output logic                cs_n_o,
  output logic                busy_o,
  output logic                rx_ovf_o,
  input  logic                ovf_clr_i
);
  localparam int DW  = DATA_WIDTH;
  localparam int HCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HPW = $clog2(2 * DW);

  localparam logic [HCW-1:0] HC_LAST = HCW'(CLK_DIV - 1);
  localparam logic [HPW-1:0] HP_LAST = HPW'(2 * DW - 1);
  localparam logic [HPW-1:0] HP_LFALL = HPW'(2 * DW - 2);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SETUP, SHIFT, PUSH, GAP
  } state_t;

  state_t          state;
  logic [HCW-1:0]  hc;
  logic [HPW-1:0]  hp;
  logic [DW-1:0]   shreg;
  logic [DW-1:0]   rxreg;

  // shreg holds the bits still to be sent, already aligned so that its
  // MSB is the next mosi_o value at the coming falling edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      hc             <= '0;
      hp             <= '0;
      shreg          <= '0;
      rxreg          <= '0;
      fifo.tx_rd_o   <= 1'b0;
      fifo.rx_wr_o   <= 1'b0;
      fifo.rx_data_o <= '0;
      sclk_o         <= 1'b0;
      mosi_o         <= 1'b0;
      cs_n_o         <= 1'b1;
      busy_o         <= 1'b0;
      rx_ovf_o       <= 1'b0;
    end else begin
      fifo.tx_rd_o <= 1'b0;
      fifo.rx_wr_o <= 1'b0;
      if (ovf_clr_i) rx_ovf_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en_i && !fifo.tx_empty_i) begin
            state        <= FETCH;
            fifo.tx_rd_o <= 1'b1;
            busy_o       <= 1'b1;
            hc           <= '0;
          end
        end
        FETCH: begin
          state <= LOAD;
          hc    <= '0;
        end
        LOAD: begin
          shreg  <= {fifo.tx_data_i[DW-2:0], 1'b0};
          mosi_o <= fifo.tx_data_i[DW-1];
          cs_n_o <= 1'b0;
          hc     <= '0;
          state  <= SETUP;
        end
        SETUP: begin
          if (hc == HC_LAST) begin
            hc     <= '0;
            hp     <= '0;
            sclk_o <= 1'b1;
            rxreg  <= {rxreg[DW-2:0], miso_i};
            state  <= SHIFT;
          end else begin
            hc <= hc + 1'b1;
          end
        end
        SHIFT: begin
          if (hc == HC_LAST) begin
            hc <= '0;
            if (hp == HP_LAST) begin
              state <= PUSH;
            end else begin
              hp     <= hp + 1'b1;
              sclk_o <= ~sclk_o;
              if (sclk_o) begin
                // falling edge; the last one only parks sclk low
                if (hp != HP_LFALL) begin
                  mosi_o <= shreg[DW-1];
                  shreg  <= {shreg[DW-2:0], 1'b0};
                end
              end else begin
                rxreg <= {rxreg[DW-2:0], miso_i};
              end
            end
          end else begin
            hc <= hc + 1'b1;
          end
        end
        PUSH: begin
          if (!fifo.rx_full_i) begin
            fifo.rx_wr_o   <= 1'b1;
            fifo.rx_data_o <= rxreg;
          end else begin
            rx_ovf_o <= 1'b1;
          end
          cs_n_o <= 1'b1;
          hc     <= '0;
          state  <= GAP;
        end
        GAP: begin
          if (hc == HC_LAST) begin
            hc <= '0;
            if (en_i && !fifo.tx_empty_i) begin
              state        <= FETCH;
              fifo.tx_rd_o <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            hc <= hc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed/randomized bench for spi_master_shifter (DW=24, CLK_DIV=2).
// FIFOs and SPI slave are modelled here; words are rebuilt from pin bits.
module tb_spi_master_shifter;
  localparam int DW = 24;
  localparam int CD = 2;
  localparam int FRAME = 3 + CD * (2 * DW + 2);

  logic clk_i = 1'b0;
  logic rst_i, en_i, ovf_clr_i, miso_i;
  logic sclk_o, mosi_o, cs_n_o, busy_o, rx_ovf_o;

  spi_master_shifter_if #(.DATA_WIDTH(DW)) ifc ();

  spi_master_shifter #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .fifo(ifc),
    .sclk_o(sclk_o), .mosi_o(mosi_o), .miso_i(miso_i),
    .cs_n_o(cs_n_o), .busy_o(busy_o), .rx_ovf_o(rx_ovf_o),
    .ovf_clr_i(ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // TX FIFO model with registered read data
  logic [DW-1:0] tx_mem [0:63];
  int tx_wr_ptr = 0;
  int tx_rd_ptr = 0;
  int rd_empty_cnt = 0;
  assign ifc.tx_empty_i = (tx_wr_ptr == tx_rd_ptr);

  always @(posedge clk_i) begin
    if (ifc.tx_rd_o) begin
      if (tx_wr_ptr == tx_rd_ptr) rd_empty_cnt <= rd_empty_cnt + 1;
      else begin
        ifc.tx_data_i <= tx_mem[tx_rd_ptr];
        tx_rd_ptr <= tx_rd_ptr + 1;
      end
    end
  end

  // SPI slave: 0 loopback, 1 constant one, 2 random bits
  int   miso_mode = 0;
  logic miso_drv = 1'b0;
  assign miso_i = (miso_mode == 0) ? mosi_o : miso_drv;

  // pin monitor, cumulative counts
  bit mosi_bits[$];
  bit miso_bits[$];
  logic [DW-1:0] rx_words[$];
  int gaps[$];
  int rise_total = 0, rd_total = 0, busy_total = 0, cs_falls = 0;
  int ovf_clr_seen = 0, cs_hi_run = 0;
  logic sclk_q = 1'b0, cs_q = 1'b1;

  always @(negedge clk_i) begin
    if (busy_o) busy_total++;
    if (sclk_o && !sclk_q) begin
      rise_total++;
      mosi_bits.push_back(mosi_o);
      miso_bits.push_back(miso_i);
    end
    sclk_q = sclk_o;
    if (ifc.tx_rd_o) rd_total++;
    if (ifc.rx_wr_o) rx_words.push_back(ifc.rx_data_o);
    if (!cs_n_o && cs_q) begin
      cs_falls++;
      gaps.push_back(cs_hi_run);
    end
    cs_hi_run = cs_n_o ? cs_hi_run + 1 : 0;
    cs_q = cs_n_o;
    if (rx_ovf_o && ovf_clr_i) ovf_clr_seen++;
    if (miso_mode == 2) miso_drv = 1'($urandom_range(0, 1));
    else miso_drv = 1'b1;
  end

  int bit_b, rx_b, rd_b, busy_b, cs_b, rise_b, ovf_b;

  task automatic snap();
    bit_b  = mosi_bits.size();
    rx_b   = rx_words.size();
    rd_b   = rd_total;
    busy_b = busy_total;
    cs_b   = cs_falls;
    rise_b = rise_total;
    ovf_b  = ovf_clr_seen;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    tx_mem[tx_wr_ptr] = w;
    tx_wr_ptr++;
  endtask

  task automatic wait_busy(input logic lvl, input int limit,
                           input string tag);
    int n = 0;
    while (busy_o !== lvl && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, {31'd0, busy_o}, {31'd0, lvl});
  endtask

  task automatic run_frames(input string tag, input int limit);
    wait_busy(1'b1, 20, {tag, "_start"});
    wait_busy(1'b0, limit, {tag, "_end"});
  endtask

  // word k of the current test, MSB first, rebuilt from pin samples
  function automatic logic [DW-1:0] pin_word(input bit from_miso,
                                             input int k);
    logic [DW-1:0] w = '0;
    for (int i = 0; i < DW; i++)
      w = {w[DW-2:0], from_miso ? miso_bits[bit_b + k * DW + i]
                                : mosi_bits[bit_b + k * DW + i]};
    return w;
  endfunction

  logic [DW-1:0] w3 [0:2];
  logic [DW-1:0] w;
  int mn;

  initial begin
    rst_i = 1'b1; en_i = 1'b0; ovf_clr_i = 1'b0;
    ifc.rx_full_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_tx_rd", {31'd0, ifc.tx_rd_o}, 0);
    check("rst_rx_wr", {31'd0, ifc.rx_wr_o}, 0);
    check("rst_rx_data", {8'd0, ifc.rx_data_o}, 0);
    check("rst_sclk", {31'd0, sclk_o}, 0);
    check("rst_mosi", {31'd0, mosi_o}, 0);
    check("rst_cs_n", {31'd0, cs_n_o}, 1);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_ovf", {31'd0, rx_ovf_o}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // loopback: fixed word then random words
    miso_mode = 0;
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? 24'hA5C3F0 : 24'($urandom);
      snap();
      push_word(w);
      en_i = 1'b1;
      run_frames("loop", 400);
      check("loop_pops", rd_total - rd_b, 1);
      check("loop_rises", rise_total - rise_b, DW);
      check("loop_period", busy_total - busy_b, FRAME);
      check("loop_mosi", {8'd0, pin_word(0, 0)}, {8'd0, w});
      check("loop_pushes", rx_words.size() - rx_b, 1);
      check("loop_rx", {8'd0, rx_words[rx_b]}, {8'd0, w});
    end

    // miso held high, TX word 1
    miso_mode = 1;
    snap();
    push_word(24'h000001);
    run_frames("one", 400);
    check("one_mosi", {8'd0, pin_word(0, 0)}, 32'h1);
    check("one_rx", {8'd0, rx_words[rx_b]}, 32'hFFFFFF);

    // three back-to-back frames with random miso
    miso_mode = 2;
    en_i = 1'b0;
    @(negedge clk_i);
    snap();
    for (int k = 0; k < 3; k++) begin
      w3[k] = 24'($urandom);
      push_word(w3[k]);
    end
    en_i = 1'b1;
    run_frames("b2b", 1000);
    check("b2b_pops", rd_total - rd_b, 3);
    check("b2b_cs", cs_falls - cs_b, 3);
    mn = 1000;
    for (int k = 1; k < 3; k++) if (gaps[cs_b + k] < mn) mn = gaps[cs_b + k];
    check("b2b_gap", {31'd0, mn >= CD}, 1);
    check("b2b_pushes", rx_words.size() - rx_b, 3);
    for (int k = 0; k < 3; k++) begin
      check("b2b_mosi", {8'd0, pin_word(0, k)}, {8'd0, w3[k]});
      check("b2b_rx", {8'd0, rx_words[rx_b + k]}, {8'd0, pin_word(1, k)});
    end

    // RX full: dropped word, sticky overflow
    miso_mode = 0;
    ifc.rx_full_i = 1'b1;
    snap();
    push_word(24'($urandom));
    run_frames("full", 400);
    check("full_nopush", rx_words.size() - rx_b, 0);
    check("full_ovf", {31'd0, rx_ovf_o}, 1);
    ifc.rx_full_i = 1'b0;
    snap();
    push_word(24'h123456);
    run_frames("full2", 400);
    check("full2_push", rx_words.size() - rx_b, 1);
    check("full2_sticky", {31'd0, rx_ovf_o}, 1);
    ovf_clr_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("clr_ovf", {31'd0, rx_ovf_o}, 0);
    ifc.rx_full_i = 1'b1;
    snap();
    push_word(24'h654321);
    run_frames("clrset", 400);
    check("clrset_wins", {31'd0, ovf_clr_seen > ovf_b}, 1);
    ifc.rx_full_i = 1'b0;
    repeat (2) @(negedge clk_i);
    ovf_clr_i = 1'b0;

    // reset in SHIFT half-period 10 (sixth rising edge)
    snap();
    push_word(24'($urandom));
    for (int n = 0; n < 300 && rise_total - rise_b < 6; n++)
      @(negedge clk_i);
    check("rst_reach", rise_total - rise_b, 6);
    rst_i = 1'b1;
    en_i = 1'b0;
    @(negedge clk_i);
    check("abort_cs_n", {31'd0, cs_n_o}, 1);
    check("abort_sclk", {31'd0, sclk_o}, 0);
    check("abort_busy", {31'd0, busy_o}, 0);
    rst_i = 1'b0;
    en_i = 1'b1;
    repeat (60) @(negedge clk_i);
    check("abort_nopush", rx_words.size() - rx_b, 0);
    check("abort_pops", rd_total - rd_b, 1);

    // empty FIFO with en high, then en dropped mid-frame
    snap();
    repeat (20) @(negedge clk_i);
    check("empty_nopop", rd_total - rd_b, 0);
    check("empty_idle", {31'd0, busy_o}, 0);
    push_word(24'($urandom));
    wait_busy(1'b1, 20, "drop_start");
    for (int n = 0; n < 300 && rise_total - rise_b < 3; n++)
      @(negedge clk_i);
    en_i = 1'b0;
    push_word(24'($urandom));
    wait_busy(1'b0, 400, "drop_end");
    check("drop_push", rx_words.size() - rx_b, 1);
    repeat (20) @(negedge clk_i);
    check("drop_idle", {31'd0, busy_o}, 0);
    check("drop_pops", rd_total - rd_b, 1);
    check("rd_while_empty", rd_empty_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
